// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the framed UART receiver
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rxd synchroniser, falling-edge detector and 3-sample majority voter
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int CNT_W       = $clog2(OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             rxd,
    input  logic [CNT_W-1:0] tick_cnt,
    output logic             rxd_s,
    output logic             fall,
    output logic             vote
);

    localparam int MID = OVERSAMPLE / 2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [1:0]             samp_q;

    // Metastability chain on the asynchronous line; idles high like the line itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Per-tick history: previous sample for edge detection, plus the two early vote samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
            samp_q <= 2'b11;
        end else if (tick) begin
            prev_q <= rxd_s;
            if (tick_cnt == CNT_W'(MID - 1)) samp_q[0] <= rxd_s;
            if (tick_cnt == CNT_W'(MID))     samp_q[1] <= rxd_s;
        end
    end

    assign fall = prev_q & ~rxd_s;
    // Third sample is the live one, so the vote is valid on the mid+1 tick itself.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - parametrised UART receiver with error flags and valid/ready output
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int PARITY      = PAR_NONE,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int MID   = OVERSAMPLE / 2;

    localparam logic [CNT_W-1:0] TICK_VOTE = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 commit_q, commit_d;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 perr_out_q;
    logic                 ferr_out_q;
    logic                 overrun_q;

    logic                 rxd_s_unused;
    logic                 fall;
    logic                 vote;
    logic                 at_vote;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .OVERSAMPLE  (OVERSAMPLE),
        .CNT_W       (CNT_W)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .rxd      (rxd),
        .tick_cnt (tick_cnt_q),
        .rxd_s    (rxd_s_unused),
        .fall     (fall),
        .vote     (vote)
    );

    // Frame sequencing: every decision is taken on the mid+1 tick of a bit.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        commit_d   = 1'b0;
        at_vote    = (tick_cnt_q == TICK_VOTE);
        if (tick) begin
            if (state_q != ST_IDLE) begin
                tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                    end
                end
                ST_START: begin
                    if (at_vote) state_d = vote ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (at_vote) begin
                        shift_d = {vote, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_vote) begin
                        perr_d  = (((^shift_q) ^ vote) != (PARITY == PAR_ODD));
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (at_vote) begin
                        if (!vote) ferr_d = 1'b1;
                        if (bit_cnt_q == STOP_LAST) begin
                            commit_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Frame state registers; commit is a one-clk pulse following the last stop vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            commit_q   <= commit_d;
        end
    end

    // Output word and handshake; a finished frame is dropped if the previous word is still unread.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (commit_q) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q  <= shift_q;
                    perr_out_q <= perr_q;
                    ferr_out_q <= ferr_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - self-checking bench for uart_rx_framed in 8N1, 8E1 and 7O2 configurations
module tb_uart_rx_framed;

    typedef struct {
        int         d;
        logic [8:0] data;
        int         par;
        logic [1:0] stops;
        logic [8:0] edata;
        logic       eperr;
        logic       eferr;
    } vec_t;

    typedef struct {
        int         d;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [2:0] rxd_v;
    logic [2:0] ready_v;
    logic [2:0] valid_v;
    logic [2:0] perr_v;
    logic [2:0] ferr_v;
    logic [2:0] ovr_v;
    logic [2:0] busy_v;
    logic [7:0] rx_data_a;
    logic [7:0] rx_data_b;
    logic [6:0] rx_data_c;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   words [3] = '{0, 0, 0};
    int   ovr_cnt [3] = '{0, 0, 0};
    exp_t sb [$];
    exp_t e_mon;
    vec_t tbl [11];

    uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .rxd(rxd_v[0]), .rx_data(rx_data_a), .rx_valid(valid_v[0]),
        .rx_ready(ready_v[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]), .overrun(ovr_v[0]), .busy(busy_v[0]));

    uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .rxd(rxd_v[1]), .rx_data(rx_data_b), .rx_valid(valid_v[1]),
        .rx_ready(ready_v[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]), .overrun(ovr_v[1]), .busy(busy_v[1]));

    uart_rx_framed #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(3)) dut_c (
        .clk(clk), .rst(rst), .tick(tick), .rxd(rxd_v[2]), .rx_data(rx_data_c), .rx_valid(valid_v[2]),
        .rx_ready(ready_v[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]), .overrun(ovr_v[2]), .busy(busy_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick once every 4 clks so the sender can skew bit times at clk resolution.
    initial begin
        int c;
        c = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick = (c == 3);
            c = (c + 1) % 4;
        end
    end

    function automatic logic [8:0] get_dat(input int d);
        case (d)
            0:       return {1'b0, rx_data_a};
            1:       return {1'b0, rx_data_b};
            default: return {2'b00, rx_data_c};
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every accepted word must match the oldest expected entry.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ovr_v[d]) ovr_cnt[d]++;
            if (valid_v[d] && ready_v[d]) begin
                words[d]++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: dut %0d got %0h expected none", d, get_dat(d));
                end else begin
                    e_mon = sb.pop_front();
                    chk("word_dut", d, e_mon.d);
                    chk("word_data", int'(get_dat(d)), int'(e_mon.data));
                    chk("word_parity_err", int'(perr_v[d]), int'(e_mon.perr));
                    chk("word_frame_err", int'(ferr_v[d]), int'(e_mon.ferr));
                end
            end
        end
    end

    task automatic put(input int d, input logic b, input int n);
        rxd_v[d] = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [8:0] data, input int par, input logic [1:0] stops, input int bclk);
        int nb;
        int ns;
        nb = (d == 2) ? 7 : 8;
        ns = (d == 2) ? 2 : 1;
        put(d, 1'b0, bclk);
        for (int i = 0; i < nb; i++) put(d, data[i], bclk);
        if (par >= 0) put(d, par[0], bclk);
        for (int i = 0; i < ns; i++) put(d, stops[i], bclk);
        put(d, 1'b1, 2 * bclk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        int w0;
        int o0;
        int bc;
        tbl[0]  = '{0, 9'h03C, -1, 2'b11, 9'h03C, 1'b0, 1'b0};
        tbl[1]  = '{0, 9'h0A5, -1, 2'b11, 9'h0A5, 1'b0, 1'b0};
        tbl[2]  = '{0, 9'h055, -1, 2'b10, 9'h055, 1'b0, 1'b1};
        tbl[3]  = '{0, 9'h000, -1, 2'b11, 9'h000, 1'b0, 1'b0};
        tbl[4]  = '{0, 9'h0FF, -1, 2'b11, 9'h0FF, 1'b0, 1'b0};
        tbl[5]  = '{1, 9'h007,  0, 2'b11, 9'h007, 1'b1, 1'b0};
        tbl[6]  = '{1, 9'h007,  1, 2'b11, 9'h007, 1'b0, 1'b0};
        tbl[7]  = '{1, 9'h080,  1, 2'b11, 9'h080, 1'b0, 1'b0};
        tbl[8]  = '{2, 9'h05A,  1, 2'b11, 9'h05A, 1'b0, 1'b0};
        tbl[9]  = '{2, 9'h05A,  1, 2'b01, 9'h05A, 1'b0, 1'b1};
        tbl[10] = '{2, 9'h05A,  0, 2'b11, 9'h05A, 1'b1, 1'b0};

        rst = 1'b1;
        rxd_v = 3'b111;
        ready_v = 3'b111;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_valid", int'(valid_v), 0);
        chk("reset_busy", int'(busy_v), 0);
        chk("reset_overrun", int'(ovr_v), 0);
        chk("reset_errs", int'({perr_v, ferr_v}), 0);
        chk("reset_data_a", int'(get_dat(0)), 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Start glitch: 4 ticks low must be rejected without a word.
        w0 = words[0];
        rxd_v[0] = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rxd_v[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("glitch_busy_during", int'(busy_v[0]), 1);
        repeat (64) @(posedge clk);
        #1;
        chk("glitch_busy_after", int'(busy_v[0]), 0);
        chk("glitch_no_word", words[0] - w0, 0);
        chk("glitch_valid", int'(valid_v[0]), 0);

        for (int i = 0; i < 11; i++) begin
            bc = (tbl[i].d == 2) ? 32 : 64;
            sb.push_back('{tbl[i].d, tbl[i].edata, tbl[i].eperr, tbl[i].eferr});
            send(tbl[i].d, tbl[i].data, tbl[i].par, tbl[i].stops, bc);
            wait_drain();
        end

        // Break: line low for three frame times gives exactly one all-zero framing error.
        w0 = words[0];
        sb.push_back('{0, 9'h000, 1'b0, 1'b1});
        rxd_v[0] = 1'b0;
        repeat (1920) @(posedge clk);
        #1;
        rxd_v[0] = 1'b1;
        repeat (256) @(posedge clk);
        wait_drain();
        chk("break_one_word", words[0] - w0, 1);
        chk("break_busy", int'(busy_v[0]), 0);

        // Overrun: second frame is dropped while the first is unread.
        o0 = ovr_cnt[0];
        ready_v[0] = 1'b0;
        sb.push_back('{0, 9'h011, 1'b0, 1'b0});
        send(0, 9'h011, -1, 2'b11, 64);
        send(0, 9'h022, -1, 2'b11, 64);
        chk("ovr_valid_held", int'(valid_v[0]), 1);
        chk("ovr_data_held", int'(get_dat(0)), 9'h011);
        chk("ovr_pulse_count", ovr_cnt[0] - o0, 1);
        ready_v[0] = 1'b1;
        wait_drain();
        @(posedge clk);
        #1;
        chk("ovr_accept_clears", int'(valid_v[0]), 0);

        // Reset in the middle of the data bits: nothing may come out.
        w0 = words[0];
        rxd_v[0] = 1'b0;
        repeat (256) @(posedge clk);
        #1;
        chk("rstmid_busy_before", int'(busy_v[0]), 1);
        rxd_v[0] = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (1300) @(posedge clk);
        #1;
        chk("rstmid_busy_after", int'(busy_v[0]), 0);
        chk("rstmid_no_word", words[0] - w0, 0);
        chk("rstmid_valid", int'(valid_v[0]), 0);

        // Baud offset of about +/-3% on 0xC3.
        sb.push_back('{0, 9'h0C3, 1'b0, 1'b0});
        send(0, 9'h0C3, -1, 2'b11, 66);
        wait_drain();
        sb.push_back('{0, 9'h0C3, 1'b0, 1'b0});
        send(0, 9'h0C3, -1, 2'b11, 62);
        wait_drain();

        chk("overrun_total_a", ovr_cnt[0], 1);
        chk("overrun_total_b", ovr_cnt[1], 0);
        chk("overrun_total_c", ovr_cnt[2], 0);
        chk("words_b", words[1], 3);
        chk("words_c", words[2], 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
